soft_error_hub_v2: RTL and testbench
====================================

# soft_error_hub_v2

Parametrised successor to the per-bank soft-error hub: collects raw A/B error flags from an externally instantiated array of `soft_error_detector_top_V2` instances, organised as `N_BANK` banks of `N_DET` detectors each. Per bank it provides:

- a live OR of the error flags;
- sticky flags;
- saturating event counters.

It also captures a first-error record and supports a 4-phase clear handshake. It sits between the detector arrays and the readout/logging logic.

## Interface
Parameters:
- `N_BANK`, 7, number of banks (≥1)
- `N_DET`, 20, detectors per bank (≥1); unused slots are tied low by the instantiator
- `CNT_W`, 16, width of each per-bank event counter
- `BANK_W`, `$clog2(N_BANK)` (min 1), bank index width (derived)
- `DET_W`, `$clog2(N_DET)` (min 1), detector index width (derived)

Ports:
- `i_clk`  in  1  system clock; the single clock domain
- `i_rst`  in  1  synchronous, active-low reset
- `i_err_A`  in  `N_BANK*N_DET`  raw A flags; bit `b*N_DET+d` is bank b, detector d
- `i_err_B`  in  `N_BANK*N_DET`  raw B flags, same layout
- `i_bank_mask`  in  `N_BANK`  1 = bank ignored for all outputs
- `i_clr_req`  in  1  clear request (4-phase)
- `o_clr_ack`  out  1  clear acknowledge
- `o_err_A`, `o_err_B`  out  `N_BANK` each  live per-bank OR
- `o_sticky_A`, `o_sticky_B`  out  `N_BANK` each  latched per-bank flags
- `o_cnt_A`, `o_cnt_B`  out  `N_BANK*CNT_W` each  per-bank rising-edge counts; bank b occupies `[b*CNT_W +: CNT_W]`
- `o_first_vld`  out  1  first-error record valid
- `o_first_bank`  out  `BANK_W`  bank of the first error
- `o_first_det`  out  `DET_W`  detector of the first error
- `o_first_ch`  out  1  channel of the first error; 0 = A, 1 = B

## Operation
- Stage 1: `i_err_A`/`i_err_B` are registered into `r1`.
- Stage 2: the previous `r1` is held in `r2`.
- Event definition: `ev = r1 & ~r2`, per bit. A masked bank produces no events.
- `o_err_X[b]` (X = A or B): registered OR of the bank-b slice of `r1`; forced to 0 when `i_bank_mask[b]` is set.
- Sticky flags: `o_sticky_X[b]` sets on any `ev` in bank b and holds until a clear.
- Counters: `o_cnt_X[b]` adds popcount(bank-b `ev`) each cycle and saturates at `2^CNT_W-1`. Multiple simultaneous rising edges in one bank all count.
- First-error record:
  - While `o_first_vld`=0, the first cycle with any unmasked `ev` loads bank, detector and channel, and sets `o_first_vld`.
  - Priority within that cycle: lowest bank, then lowest detector, then A before B.
  - The record is frozen until a clear.
- Clear handshake:
  - A clear is performed on any edge where `i_clr_req`=1 and `o_clr_ack`=0. It zeroes sticky flags, counters and the first-error record.
  - `o_clr_ack` rises on the next edge and stays high while `i_clr_req`=1. It falls on the edge after `i_clr_req` falls.
  - A new request is honoured only once `o_clr_ack`=0.
- Clear coinciding with an event: the event wins.
  - Counter loads that cycle's popcount instead of 0.
  - Sticky flag stays set.
  - First-error record reloads from that cycle's events.
- Mask changes take effect on the next edge. They do not alter already accumulated sticky flags, counters or the first-error record.
- The live OR `o_err_X` is never affected by a clear.

## Timing
- Reset (`i_rst`=0 at an edge): `r1`, `r2`, all outputs, counters, sticky flags, `o_first_*` and `o_clr_ack` go to 0. A reset in the middle of a handshake aborts it.
- Latency from a raw flag rising to `o_err_X`, sticky flag, counter and first-error update: 2 edges.
- Latency from `i_clr_req` rising to the clear taking effect: 1 edge.
- Latency from `i_clr_req` rising to `o_clr_ack` high: 2 edges.
- A flag held high counts once. It counts again only after low for at least one cycle.
- Glitch-free flags toggling every cycle count on every rise.

## Structure
- Package `soft_err_hub_pkg`: default constants, a `clog2`-with-minimum-1 function, and the channel encoding (`CH_A`=0, `CH_B`=1).
- Sub-module `soft_err_bank_agg`, instantiated once per bank via generate. It contains the `r1`/`r2` slices, the edge detect, the masked OR, sticky flags, the popcount and the saturating counter. It exports its per-bank `ev` vector.
- The top level contains the first-error priority encoder across banks and the clear FSM. Clear FSM states: IDLE → ACK (on req) → IDLE (on req low).

## Test plan
- Reset, then pulse bank 2 detector 5 A for 1 cycle → 2 edges later, `o_err_A[2]`=1 for 1 cycle; `o_sticky_A[2]`=1; `o_cnt_A` bank 2 = 1; first record = (2,5,A).
- Same cycle: bank 3 det 0 B, bank 1 det 7 A, bank 1 det 7 B all rise → first record = (1,7,A); bank-1 A count 1, bank-1 B count 1, bank-3 B count 1.
- `CNT_W`=4: toggle bank 0 det 0 A for 20 rises → count holds at 15.
- `i_bank_mask[4]`=1 with bank 4 flags active → `o_err_*[4]`=0, bank-4 counters stay 0, first-record valid stays 0.
- Clear request arrives on the same edge as a bank 6 det 3 B rise → ack after 2 edges; bank-6 B count = 1, sticky still set, first record = (6,3,B).
- Assert `i_rst`=0 while `o_clr_ack`=1 → all outputs 0 on the next edge; after reset is released, a held `i_clr_req` starts a new handshake.

Source files
------------

// File: rtl/soft_err_hub_pkg.sv
// Shared constants, channel encoding and the index-width helper for the soft-error hub.
package soft_err_hub_pkg;

    localparam int N_BANK_DEF = 7;
    localparam int N_DET_DEF  = 20;
    localparam int CNT_W_DEF  = 16;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_ACK  = 1'b1
    } clr_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/soft_err_bank_agg.sv
// One bank of detectors: two-stage flag capture, rising-edge events, masked live OR,
// sticky flags and saturating event counters for both channels.
module soft_err_bank_agg
    import soft_err_hub_pkg::*;
#(
    parameter int N_DET = N_DET_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_DET-1:0]   raw_a,
    input  logic [N_DET-1:0]   raw_b,
    input  logic               mask,
    input  logic               clr,
    output logic               err_a,
    output logic               err_b,
    output logic               sticky_a,
    output logic               sticky_b,
    output logic [CNT_W-1:0]   cnt_a,
    output logic [CNT_W-1:0]   cnt_b,
    output logic [N_DET-1:0]   ev_a,
    output logic [N_DET-1:0]   ev_b
);

    localparam int PC_W  = $clog2(N_DET + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [1:0][N_DET-1:0] r1, r2, ev;
    logic [1:0][PC_W-1:0]  pop;
    logic [1:0][SUM_W-1:0] sum;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            st_q, st_d, or_q, or_d;

    // A clear in the same cycle as an event restarts from that cycle's events.
    always_comb begin
        ev    = '0;
        pop   = '0;
        sum   = '0;
        cnt_d = cnt_q;
        st_d  = st_q;
        or_d  = '0;
        for (int ch = 0; ch < 2; ch++) begin
            ev[ch] = r1[ch] & ~r2[ch] & {N_DET{~mask}};
            for (int d = 0; d < N_DET; d++) begin
                pop[ch] = pop[ch] + PC_W'(ev[ch][d]);
            end
            sum[ch]   = (clr ? '0 : SUM_W'(cnt_q[ch])) + SUM_W'(pop[ch]);
            cnt_d[ch] = (sum[ch] > CNT_MAX) ? {CNT_W{1'b1}} : sum[ch][CNT_W-1:0];
            st_d[ch]  = (st_q[ch] & ~clr) | (|ev[ch]);
            or_d[ch]  = (|r1[ch]) & ~mask;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r1    <= '0;
            r2    <= '0;
            cnt_q <= '0;
            st_q  <= '0;
            or_q  <= '0;
        end else begin
            r1[CH_A] <= raw_a;
            r1[CH_B] <= raw_b;
            r2       <= r1;
            cnt_q    <= cnt_d;
            st_q     <= st_d;
            or_q     <= or_d;
        end
    end

    assign err_a    = or_q[CH_A];
    assign err_b    = or_q[CH_B];
    assign sticky_a = st_q[CH_A];
    assign sticky_b = st_q[CH_B];
    assign cnt_a    = cnt_q[CH_A];
    assign cnt_b    = cnt_q[CH_B];
    assign ev_a     = ev[CH_A];
    assign ev_b     = ev[CH_B];

endmodule

// File: rtl/soft_error_hub_v2.sv
// Soft-error hub: per-bank aggregation of detector flags, first-error capture across
// banks and a 4-phase clear handshake.
module soft_error_hub_v2
    import soft_err_hub_pkg::*;
#(
    parameter int N_BANK = N_BANK_DEF,
    parameter int N_DET  = N_DET_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int BANK_W = clog2_min1(N_BANK),
    parameter int DET_W  = clog2_min1(N_DET)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_BANK*N_DET-1:0]   i_err_A,
    input  logic [N_BANK*N_DET-1:0]   i_err_B,
    input  logic [N_BANK-1:0]         i_bank_mask,
    input  logic                      i_clr_req,
    output logic                      o_clr_ack,
    output logic [N_BANK-1:0]         o_err_A,
    output logic [N_BANK-1:0]         o_err_B,
    output logic [N_BANK-1:0]         o_sticky_A,
    output logic [N_BANK-1:0]         o_sticky_B,
    output logic [N_BANK*CNT_W-1:0]   o_cnt_A,
    output logic [N_BANK*CNT_W-1:0]   o_cnt_B,
    output logic                      o_first_vld,
    output logic [BANK_W-1:0]         o_first_bank,
    output logic [DET_W-1:0]          o_first_det,
    output logic                      o_first_ch
);

    logic [N_BANK-1:0][N_DET-1:0] ev_a, ev_b;
    clr_state_t                   state_q, state_d;
    logic                         clr_go, ack_d;

    for (genvar b = 0; b < N_BANK; b++) begin : g_bank
        soft_err_bank_agg #(
            .N_DET (N_DET),
            .CNT_W (CNT_W)
        ) u_bank (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .raw_a    (i_err_A[b*N_DET +: N_DET]),
            .raw_b    (i_err_B[b*N_DET +: N_DET]),
            .mask     (i_bank_mask[b]),
            .clr      (clr_go),
            .err_a    (o_err_A[b]),
            .err_b    (o_err_B[b]),
            .sticky_a (o_sticky_A[b]),
            .sticky_b (o_sticky_B[b]),
            .cnt_a    (o_cnt_A[b*CNT_W +: CNT_W]),
            .cnt_b    (o_cnt_B[b*CNT_W +: CNT_W]),
            .ev_a     (ev_a[b]),
            .ev_b     (ev_b[b])
        );
    end

    // Clear fires once per handshake, on the edge that leaves IDLE; ack follows one edge later.
    always_comb begin
        state_d = state_q;
        clr_go  = 1'b0;
        ack_d   = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (i_clr_req) begin
                    clr_go  = 1'b1;
                    state_d = CLR_ACK;
                end
            end
            CLR_ACK: begin
                ack_d = i_clr_req;
                if (!i_clr_req) state_d = CLR_IDLE;
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= CLR_IDLE;
            o_clr_ack <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_clr_ack <= ack_d;
        end
    end

    logic              hit;
    logic [BANK_W-1:0] hit_bank;
    logic [DET_W-1:0]  hit_det;
    logic              hit_ch;

    // Scan from the top down so the lowest bank/detector, A before B, is the last writer.
    always_comb begin
        hit      = 1'b0;
        hit_bank = '0;
        hit_det  = '0;
        hit_ch   = CH_A;
        for (int b = N_BANK - 1; b >= 0; b--) begin
            for (int d = N_DET - 1; d >= 0; d--) begin
                if (ev_b[b][d]) begin
                    hit      = 1'b1;
                    hit_bank = BANK_W'(b);
                    hit_det  = DET_W'(d);
                    hit_ch   = CH_B;
                end
                if (ev_a[b][d]) begin
                    hit      = 1'b1;
                    hit_bank = BANK_W'(b);
                    hit_det  = DET_W'(d);
                    hit_ch   = CH_A;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst || (clr_go && !hit)) begin
            o_first_vld  <= 1'b0;
            o_first_bank <= '0;
            o_first_det  <= '0;
            o_first_ch   <= CH_A;
        end else if (hit && (!o_first_vld || clr_go)) begin
            o_first_vld  <= 1'b1;
            o_first_bank <= hit_bank;
            o_first_det  <= hit_det;
            o_first_ch   <= hit_ch;
        end
    end

endmodule

// File: tb/tb_soft_error_hub_v2.sv
// Directed plus random stimulus for soft_error_hub_v2 against a cycle model with an
// expected-output queue, followed by test-plan spot checks.
module tb_soft_error_hub_v2;

    localparam int NB = 7;
    localparam int ND = 20;
    localparam int CW = 4;
    localparam int BW = 3;
    localparam int DW = 5;
    localparam int NW = NB * ND;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NW-1:0]     i_err_A, i_err_B;
    logic [NB-1:0]     i_bank_mask;
    logic              i_clr_req;
    logic              o_clr_ack;
    logic [NB-1:0]     o_err_A, o_err_B, o_sticky_A, o_sticky_B;
    logic [NB*CW-1:0]  o_cnt_A, o_cnt_B;
    logic              o_first_vld;
    logic [BW-1:0]     o_first_bank;
    logic [DW-1:0]     o_first_det;
    logic              o_first_ch;

    always #5 i_clk = ~i_clk;

    soft_error_hub_v2 #(.N_BANK(NB), .N_DET(ND), .CNT_W(CW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_err_A      (i_err_A),
        .i_err_B      (i_err_B),
        .i_bank_mask  (i_bank_mask),
        .i_clr_req    (i_clr_req),
        .o_clr_ack    (o_clr_ack),
        .o_err_A      (o_err_A),
        .o_err_B      (o_err_B),
        .o_sticky_A   (o_sticky_A),
        .o_sticky_B   (o_sticky_B),
        .o_cnt_A      (o_cnt_A),
        .o_cnt_B      (o_cnt_B),
        .o_first_vld  (o_first_vld),
        .o_first_bank (o_first_bank),
        .o_first_det  (o_first_det),
        .o_first_ch   (o_first_ch)
    );

    typedef struct packed {
        logic [NB-1:0]    err_a, err_b, st_a, st_b;
        logic [NB*CW-1:0] cnt_a, cnt_b;
        logic             fv;
        logic [BW-1:0]    fb;
        logic [DW-1:0]    fd;
        logic             fch;
        logic             ack;
    } exp_t;

    exp_t          q[$];
    exp_t          m;
    logic [NW-1:0] h1a, h1b, h2a, h2b;
    logic          m_armed;
    int            checks = 0;
    int            errors = 0;

    function automatic int bit_of(input int b, input int d);
        return b * ND + d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected outputs after the coming edge, from the inputs currently driven.
    task automatic model_edge();
        exp_t          e;
        logic [NW-1:0] eva, evb;
        logic          clr, hit;
        int            c;
        e = m;
        if (!i_rst) begin
            e = '0;
            h1a = '0; h1b = '0; h2a = '0; h2b = '0;
            m_armed = 1'b0;
        end else begin
            eva = h1a & ~h2a;
            evb = h1b & ~h2b;
            clr = i_clr_req && !m_armed;
            for (int b = 0; b < NB; b++) begin
                if (i_bank_mask[b]) begin
                    eva[b*ND +: ND] = '0;
                    evb[b*ND +: ND] = '0;
                end
                e.err_a[b] = (|h1a[b*ND +: ND]) && !i_bank_mask[b];
                e.err_b[b] = (|h1b[b*ND +: ND]) && !i_bank_mask[b];
                e.st_a[b]  = (m.st_a[b] && !clr) || (|eva[b*ND +: ND]);
                e.st_b[b]  = (m.st_b[b] && !clr) || (|evb[b*ND +: ND]);
                c = clr ? 0 : int'(m.cnt_a[b*CW +: CW]);
                c = c + $countones(eva[b*ND +: ND]);
                e.cnt_a[b*CW +: CW] = CW'((c > 15) ? 15 : c);
                c = clr ? 0 : int'(m.cnt_b[b*CW +: CW]);
                c = c + $countones(evb[b*ND +: ND]);
                e.cnt_b[b*CW +: CW] = CW'((c > 15) ? 15 : c);
            end
            if (!m.fv || clr) begin
                hit = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    for (int d = 0; d < ND; d++) begin
                        if (!hit && eva[bit_of(b, d)]) begin
                            hit = 1'b1; e.fb = BW'(b); e.fd = DW'(d); e.fch = 1'b0;
                        end
                        if (!hit && evb[bit_of(b, d)]) begin
                            hit = 1'b1; e.fb = BW'(b); e.fd = DW'(d); e.fch = 1'b1;
                        end
                    end
                end
                if (hit) e.fv = 1'b1;
                else if (clr) begin
                    e.fv = 1'b0; e.fb = '0; e.fd = '0; e.fch = 1'b0;
                end
            end
            e.ack   = m_armed && i_clr_req;
            m_armed = i_clr_req;
            h2a = h1a; h2b = h1b;
            h1a = i_err_A; h1b = i_err_B;
        end
        m = e;
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_edge();
        @(posedge i_clk);
        #1;
        e = q.pop_front();
        chk("err_a", o_err_A, e.err_a);
        chk("err_b", o_err_B, e.err_b);
        chk("sticky_a", o_sticky_A, e.st_a);
        chk("sticky_b", o_sticky_B, e.st_b);
        chk("cnt_a", o_cnt_A, e.cnt_a);
        chk("cnt_b", o_cnt_B, e.cnt_b);
        chk("first", {o_first_vld, o_first_bank, o_first_det, o_first_ch},
            {e.fv, e.fb, e.fd, e.fch});
        chk("clr_ack", o_clr_ack, e.ack);
    endtask

    task automatic do_clear();
        i_clr_req = 1'b1;
        tick();
        chk("hs_ack_low_at_clear", o_clr_ack, 0);
        tick();
        chk("hs_ack_high", o_clr_ack, 1);
        tick();
        i_clr_req = 1'b0;
        tick();
        chk("hs_ack_fall", o_clr_ack, 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        i_rst = 1'b0; i_err_A = '0; i_err_B = '0; i_bank_mask = '0; i_clr_req = 1'b0;
        h1a = '0; h1b = '0; h2a = '0; h2b = '0; m = '0; m_armed = 1'b0;

        tick(); tick();
        chk("rst_cnt_a", o_cnt_A, 0);
        chk("rst_first_vld", o_first_vld, 0);
        chk("rst_ack", o_clr_ack, 0);
        i_rst = 1'b1;
        tick();

        // single pulse bank 2 det 5 A
        i_err_A[bit_of(2, 5)] = 1'b1; tick();
        i_err_A = '0; tick();
        chk("p1_err_a2", o_err_A[2], 1);
        chk("p1_sticky_a2", o_sticky_A[2], 1);
        chk("p1_cnt_a2", o_cnt_A[2*CW +: CW], 1);
        chk("p1_first", {o_first_vld, o_first_bank, o_first_det, o_first_ch}, {1'b1, 3'd2, 5'd5, 1'b0});
        tick();
        chk("p1_err_a2_drop", o_err_A[2], 0);
        chk("p1_sticky_hold", o_sticky_A[2], 1);
        do_clear();
        chk("clr_zero_cnt", o_cnt_A, 0);

        // simultaneous rises, priority
        i_err_B[bit_of(3, 0)] = 1'b1; i_err_A[bit_of(1, 7)] = 1'b1; i_err_B[bit_of(1, 7)] = 1'b1;
        tick();
        i_err_A = '0; i_err_B = '0; tick();
        chk("p2_first", {o_first_vld, o_first_bank, o_first_det, o_first_ch}, {1'b1, 3'd1, 5'd7, 1'b0});
        chk("p2_cnt_a1", o_cnt_A[1*CW +: CW], 1);
        chk("p2_cnt_b1", o_cnt_B[1*CW +: CW], 1);
        chk("p2_cnt_b3", o_cnt_B[3*CW +: CW], 1);
        do_clear();

        // saturation at 15
        for (int i = 0; i < 20; i++) begin
            i_err_A[0] = 1'b1; tick();
            i_err_A[0] = 1'b0; tick();
        end
        tick();
        chk("sat_cnt_a0", o_cnt_A[0 +: CW], 15);
        do_clear();

        // masked bank 4
        i_bank_mask = 7'b001_0000;
        i_err_A[bit_of(4, 2)] = 1'b1; i_err_B[bit_of(4, 9)] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_err_A[bit_of(4, 11)] = ~i_err_A[bit_of(4, 11)];
            tick();
        end
        i_err_A[bit_of(4, 11)] = 1'b0; tick(); tick();
        chk("mask_err_a4", o_err_A[4], 0);
        chk("mask_err_b4", o_err_B[4], 0);
        chk("mask_cnt_a4", o_cnt_A[4*CW +: CW], 0);
        chk("mask_cnt_b4", o_cnt_B[4*CW +: CW], 0);
        chk("mask_first_vld", o_first_vld, 0);
        i_bank_mask = '0; tick(); tick();
        chk("unmask_err_b4", o_err_B[4], 1);
        chk("unmask_cnt_b4", o_cnt_B[4*CW +: CW], 0);
        i_err_A = '0; i_err_B = '0; tick(); tick();
        do_clear();

        // clear request on the same edge a bank 6 det 3 B flag is sampled
        i_err_B[bit_of(6, 3)] = 1'b1; i_clr_req = 1'b1; tick();
        i_err_B = '0; tick();
        chk("cc_ack", o_clr_ack, 1);
        chk("cc_cnt_b6", o_cnt_B[6*CW +: CW], 1);
        chk("cc_sticky_b6", o_sticky_B[6], 1);
        chk("cc_first", {o_first_vld, o_first_bank, o_first_det, o_first_ch}, {1'b1, 3'd6, 5'd3, 1'b1});
        i_clr_req = 1'b0; tick(); tick();

        // clear on the very edge an event is counted: event wins
        i_err_A[bit_of(0, 1)] = 1'b1; tick();
        i_err_A = '0; tick();
        i_err_A[bit_of(5, 4)] = 1'b1; tick();
        i_err_A = '0; i_clr_req = 1'b1; tick();
        chk("ew_cnt_a5", o_cnt_A[5*CW +: CW], 1);
        chk("ew_cnt_a0", o_cnt_A[0 +: CW], 0);
        chk("ew_cnt_b6", o_cnt_B[6*CW +: CW], 0);
        chk("ew_sticky_a5", o_sticky_A[5], 1);
        chk("ew_first", {o_first_vld, o_first_bank, o_first_det, o_first_ch}, {1'b1, 3'd5, 5'd4, 1'b0});
        tick();
        i_clr_req = 1'b0; tick(); tick();

        // held flag counts once
        i_err_A[bit_of(5, 1)] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("held_cnt_a5", o_cnt_A[5*CW +: CW], 2);
        i_err_A = '0; tick();
        i_err_A[bit_of(5, 1)] = 1'b1; tick(); tick();
        chk("rehit_cnt_a5", o_cnt_A[5*CW +: CW], 3);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < 3; k++) begin
                idx = int'($urandom_range(NW - 1));
                i_err_A[idx] = ~i_err_A[idx];
                idx = int'($urandom_range(NW - 1));
                i_err_B[idx] = ~i_err_B[idx];
            end
            if ($urandom_range(7) == 0) i_bank_mask = NB'($urandom);
            if ($urandom_range(5) == 0) i_clr_req = ~i_clr_req;
            tick();
        end
        i_clr_req = 1'b0; i_bank_mask = '0; tick(); tick();

        // reset in the middle of a handshake
        i_clr_req = 1'b1; tick(); tick();
        chk("mid_ack_high", o_clr_ack, 1);
        i_rst = 1'b0; tick();
        chk("mid_rst_ack", o_clr_ack, 0);
        chk("mid_rst_err", {o_err_A, o_err_B}, 0);
        chk("mid_rst_cnt", {o_cnt_A, o_cnt_B}, 0);
        chk("mid_rst_first", o_first_vld, 0);
        i_rst = 1'b1; tick();
        chk("post_rst_ack_low", o_clr_ack, 0);
        tick();
        chk("post_rst_ack_high", o_clr_ack, 1);
        i_clr_req = 1'b0; tick();
        chk("post_rst_ack_fall", o_clr_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
